ps2_keyboard_fifo: RTL

Next-generation PS/2 keyboard front end. It receives PS/2 device frames, checks start, parity and stop bits, and applies a frame timeout. It decodes the E0 (extended) and F0 (break) prefixes, tracks six modifier keys, and packs each key event into a 16-bit word. Words are buffered in a parametrised FIFO and delivered over a valid/ready handshake. The CPU-side keyboard interface no longer needs to catch a single-cycle strobe.

---
 rtl/keyboard_pkg.sv | 42 ++++
 rtl/ps2_frame_rx.sv | 112 +++++++++++
 rtl/sync_fifo.sv | 56 +++++
 rtl/ps2_keyboard_fifo.sv | 127 ++++++++++++
 4 files changed

// File: rtl/keyboard_pkg.sv
// Shared constants, receiver state encoding and key-event word layout for the PS/2 keyboard front end.
// No logic of its own; imported by the receiver and the top level.
package keyboard_pkg;

    localparam logic [7:0] PS2_EXT      = 8'hE0;
    localparam logic [7:0] PS2_BRK      = 8'hF0;

    localparam logic [7:0] CODE_SHIFT_L = 8'h12;
    localparam logic [7:0] CODE_SHIFT_R = 8'h59;
    localparam logic [7:0] CODE_CTRL    = 8'h14;
    localparam logic [7:0] CODE_ALT     = 8'h11;

    localparam int MOD_W      = 6;
    localparam int MOD_LSHIFT = 0;
    localparam int MOD_RSHIFT = 1;
    localparam int MOD_LCTRL  = 2;
    localparam int MOD_RCTRL  = 3;
    localparam int MOD_LALT   = 4;
    localparam int MOD_RALT   = 5;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

    // Field layout of the delivered word, MSB first.
    typedef struct packed {
        logic             brk;
        logic             ext;
        logic [MOD_W-1:0] mods;
        logic [7:0]       code;
    } key_word_t;

    function automatic logic [MOD_W-1:0] mod_mask(input logic [7:0] code, input logic ext);
        mod_mask = '0;
        case (code)
            CODE_SHIFT_L: mod_mask[MOD_LSHIFT] = !ext;
            CODE_SHIFT_R: mod_mask[MOD_RSHIFT] = !ext;
            CODE_CTRL:    mod_mask[ext ? MOD_RCTRL : MOD_LCTRL] = 1'b1;
            CODE_ALT:     mod_mask[ext ? MOD_RALT : MOD_LALT] = 1'b1;
            default:      mod_mask = '0;
        endcase
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: synchronises and filters the lines, checks start/parity/stop.
// Result pulses come one cycle after the filtered stop-bit falling edge; there is no backpressure.
module ps2_frame_rx
    import keyboard_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter bit CHECK_PARITY   = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_parity_err_p,
    output logic       o_frame_err_p
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    r_clk_sync;
    logic [1:0]    r_data_sync;
    logic          r_clk_filt;
    logic [FW-1:0] r_filt_cnt;
    logic [TW-1:0] r_tmo_cnt;
    logic [7:0]    r_shift;
    logic [2:0]    r_bit_cnt;
    logic          r_par_ok;
    rx_state_t     r_state;
    rx_state_t     w_state_nxt;
    logic          w_fall;
    logic          w_data;
    logic          w_tmo;
    logic          w_bv;
    logic          w_perr;
    logic          w_ferr;

    assign w_data = r_data_sync[1];
    assign w_fall = r_clk_filt && !r_clk_sync[1] && (r_filt_cnt == FW'(FILTER_LEN - 1));
    assign w_tmo  = (r_tmo_cnt == TW'(TIMEOUT_CYCLES));
    assign o_byte = r_shift;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Parity is only reported at the stop bit so the stop edge is never mistaken for a bad start.
    always_comb begin
        w_state_nxt = r_state;
        w_bv        = 1'b0;
        w_perr      = 1'b0;
        w_ferr      = 1'b0;
        if (w_tmo) begin
            w_state_nxt = IDLE;
            w_ferr      = 1'b1;
        end else if (w_fall) begin
            case (r_state)
                IDLE:    if (!w_data) w_state_nxt = DATA; else w_ferr = 1'b1;
                DATA:    if (r_bit_cnt == 3'd7) w_state_nxt = PARITY;
                PARITY:  w_state_nxt = STOP;
                STOP: begin
                    w_state_nxt = IDLE;
                    w_ferr      = !w_data;
                    w_perr      = !r_par_ok;
                    w_bv        = w_data && r_par_ok;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_clk_sync     <= 2'b11;
            r_data_sync    <= 2'b11;
            r_clk_filt     <= 1'b1;
            r_filt_cnt     <= '0;
            r_tmo_cnt      <= '0;
            r_shift        <= '0;
            r_bit_cnt      <= '0;
            r_par_ok       <= 1'b0;
            o_byte_valid   <= 1'b0;
            o_parity_err_p <= 1'b0;
            o_frame_err_p  <= 1'b0;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
            r_data_sync <= {r_data_sync[0], i_ps2_data};
            if (r_clk_sync[1] == r_clk_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
                r_filt_cnt <= '0;
                r_clk_filt <= r_clk_sync[1];
            end else begin
                r_filt_cnt <= r_filt_cnt + FW'(1);
            end
            if (w_fall || r_state == IDLE) r_tmo_cnt <= '0;
            else if (!w_tmo)               r_tmo_cnt <= r_tmo_cnt + TW'(1);
            if (r_state == IDLE) r_bit_cnt <= '0;
            if (w_fall && r_state == DATA) begin
                r_shift   <= {w_data, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_fall && r_state == PARITY) r_par_ok <= (^{r_shift, w_data}) || !CHECK_PARITY;
            o_byte_valid   <= w_bv;
            o_parity_err_p <= w_perr;
            o_frame_err_p  <= w_ferr;
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Generic synchronous first-word-fall-through FIFO with a registered read port.
// Latency: a write into an empty FIFO is visible on o_rdata/o_valid the next cycle.
// Backpressure: a write while full is ignored unless a read happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_wdata,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_rdata,
    output logic                   o_valid,
    output logic                   o_full,
    output logic [$clog2(DEPTH):0] o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_rdata;
    logic             w_wr;
    logic             w_rd;
    logic [AW-1:0]    w_rd_nxt;

    assign o_full   = (r_count == (AW+1)'(DEPTH));
    assign o_valid  = (r_count != '0);
    assign o_level  = r_count;
    assign o_rdata  = r_rdata;
    assign w_rd     = i_pop && o_valid;
    assign w_wr     = i_push && (!o_full || w_rd);
    assign w_rd_nxt = r_rd_ptr + AW'(w_rd);

    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_wdata;
    end

    // The output register preloads the next head; a write landing on that slot is bypassed.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rdata  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_wr);
            r_rd_ptr <= w_rd_nxt;
            r_count  <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_rd);
            r_rdata  <= (w_wr && (r_wr_ptr == w_rd_nxt)) ? i_wdata : r_mem[w_rd_nxt];
        end
    end

endmodule

// File: rtl/ps2_keyboard_fifo.sv
// PS/2 keyboard front end: prefix/modifier decode, packing into 16-bit words, FIFO and sticky errors.
// Word enters the FIFO 1 cycle after byte_valid; out_valid follows a cycle later when it was empty.
// Consumer stalls with out_ready=0; events arriving while the FIFO is full are dropped and flagged.
module ps2_keyboard_fifo
    import keyboard_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter bit CHECK_PARITY   = 1'b1
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_ps2_clk,
    input  logic                   i_ps2_data,
    output logic [15:0]            o_out_data,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    input  logic                   i_err_clr,
    output logic                   o_parity_err,
    output logic                   o_frame_err,
    output logic                   o_overflow,
    output logic [$clog2(DEPTH):0] o_fifo_level
);
    logic [7:0]       w_byte;
    logic             w_byte_valid;
    logic             w_perr_p;
    logic             w_ferr_p;
    logic             w_full;
    logic             w_pop;
    logic             w_ovf_p;
    logic [MOD_W-1:0] w_mask;
    logic [MOD_W-1:0] w_mod_nxt;
    logic             r_ext;
    logic             r_brk;
    logic [MOD_W-1:0] r_mod;
    logic             r_push;
    key_word_t        r_word;
    logic             r_parity_err;
    logic             r_frame_err;
    logic             r_overflow;

    ps2_frame_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CHECK_PARITY   (CHECK_PARITY)
    ) u_rx (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_ps2_clk      (i_ps2_clk),
        .i_ps2_data     (i_ps2_data),
        .o_byte         (w_byte),
        .o_byte_valid   (w_byte_valid),
        .o_parity_err_p (w_perr_p),
        .o_frame_err_p  (w_ferr_p)
    );

    assign w_mask    = mod_mask(w_byte, r_ext);
    assign w_mod_nxt = r_brk ? (r_mod & ~w_mask) : (r_mod | w_mask);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_ext  <= 1'b0;
            r_brk  <= 1'b0;
            r_mod  <= '0;
            r_push <= 1'b0;
            r_word <= '0;
        end else begin
            r_push <= 1'b0;
            if (w_byte_valid) begin
                if (w_byte == PS2_EXT) begin
                    r_ext <= 1'b1;
                end else if (w_byte == PS2_BRK) begin
                    r_brk <= 1'b1;
                end else begin
                    r_push      <= 1'b1;
                    r_word.brk  <= r_brk;
                    r_word.ext  <= r_ext;
                    r_word.mods <= w_mod_nxt;
                    r_word.code <= w_byte;
                    r_mod       <= w_mod_nxt;
                    r_ext       <= 1'b0;
                    r_brk       <= 1'b0;
                end
            end else if (w_perr_p || w_ferr_p) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end
        end
    end

    assign w_pop   = o_out_valid && i_out_ready;
    assign w_ovf_p = r_push && w_full && !w_pop;

    sync_fifo #(
        .WIDTH   (16),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (r_push),
        .i_wdata (r_word),
        .i_pop   (w_pop),
        .o_rdata (o_out_data),
        .o_valid (o_out_valid),
        .o_full  (w_full),
        .o_level (o_fifo_level)
    );

    // A new error in the same cycle as err_clr still sets its flag.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_parity_err <= (r_parity_err && !i_err_clr) || w_perr_p;
            r_frame_err  <= (r_frame_err  && !i_err_clr) || w_ferr_p;
            r_overflow   <= (r_overflow   && !i_err_clr) || w_ovf_p;
        end
    end

    assign o_parity_err = r_parity_err;
    assign o_frame_err  = r_frame_err;
    assign o_overflow   = r_overflow;

endmodule
